// File: rtl/sar_search_ctrl.sv
//==============================================================================
// sar_search_ctrl : successive-approximation search over a 16-bit comparator.
// Optional macro SAR_EARLY_EXIT_EN: cmp_eq ends the search at the current step.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sar_search_ctrl #(
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start_i,
  input  logic                cmp_gt_i,
  input  logic                cmp_lt_i,
  input  logic                cmp_eq_i,
  output logic [NUM_BITS-1:0] trial_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NUM_BITS-1:0] result_o,
  output logic                exact_o,
  output logic                err_o
);

  localparam int unsigned          IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [IDX_W-1:0]     IDX_TOP = IDX_W'(NUM_BITS - 1);
  localparam logic [NUM_BITS-1:0]  ONE     = NUM_BITS'(1);
  localparam logic [NUM_BITS-1:0]  MSB     = ONE << (NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] trial_q, trial_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] result_q, result_d;
  logic                exact_q, exact_d;
  logic                err_q, err_d;

  logic [NUM_BITS-1:0] w_bit;
  logic [NUM_BITS-1:0] w_decided;
  logic                w_legal;

  assign w_bit     = ONE << idx_q;
  assign w_decided = cmp_lt_i ? (trial_q & ~w_bit) : trial_q;
  // Exactly one flag: odd parity, but not all three.
  assign w_legal   = (cmp_gt_i ^ cmp_lt_i ^ cmp_eq_i) & ~(cmp_gt_i & cmp_lt_i & cmp_eq_i);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SEARCH;
          trial_d  = MSB;
          idx_d    = IDX_TOP;
          result_d = '0;
          exact_d  = 1'b0;
          err_d    = 1'b0;
        end
      end

      SEARCH: begin
        if (!w_legal) begin
          result_d = trial_q;
          err_d    = 1'b1;
          trial_d  = '0;
          state_d  = DONE;
        end else begin
`ifdef SAR_EARLY_EXIT_EN
          if (cmp_eq_i) begin
            result_d = trial_q;
            exact_d  = 1'b1;
            trial_d  = '0;
            state_d  = DONE;
          end else
`else
          // Equality keeps the bit; only record that it was seen.
          exact_d = exact_q | cmp_eq_i;
`endif
          if (idx_q == '0) begin
            result_d = w_decided;
            trial_d  = '0;
            state_d  = DONE;
          end else begin
            trial_d = w_decided | (w_bit >> 1);
            idx_d   = idx_q - IDX_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        trial_d = '0;
      end
    endcase
  end

  assign trial_o  = trial_q;
  assign busy_o   = (state_q == SEARCH);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign exact_o  = exact_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
//==============================================================================
// tb_sar_search_ctrl : scoreboard bench for sar_search_ctrl with a behavioural
// comparator. Revision: 1.0
//==============================================================================
`default_nettype none

module tb_sar_search_ctrl;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target = 16'h0000;
  logic        force_bad = 1'b0;
  logic        cmp_gt, cmp_lt, cmp_eq;
  logic [15:0] trial, result;
  logic        busy, done, exact, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] res;
    logic        ex;
    logic        er;
    int          lat;
    int          n0;
  } exp_t;
  exp_t sb[$];

  sar_search_ctrl #(.NUM_BITS(16)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start_i (start),
    .cmp_gt_i(cmp_gt),
    .cmp_lt_i(cmp_lt),
    .cmp_eq_i(cmp_eq),
    .trial_o (trial),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result),
    .exact_o (exact),
    .err_o   (err)
  );

  assign cmp_gt = force_bad ? 1'b1 : (target > trial);
  assign cmp_lt = force_bad ? 1'b1 : (target < trial);
  assign cmp_eq = force_bad ? 1'b0 : (target == trial);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending search.
  exp_t e;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (n_rst && done) begin
      chk("done_width", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending search");
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("exact", {31'd0, exact}, {31'd0, e.ex});
        chk("err", {31'd0, err}, {31'd0, e.er});
        chk("latency", cyc - e.n0 + 1, e.lat);
      end
    end
    done_prev = n_rst & done;
  end

  // Returns at the negedge after E0, with step-1 trial on the bus.
  task automatic run_start(input logic [15:0] tgt, input logic [15:0] res,
                           input logic ex, input logic er, input int lat);
    exp_t x;
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    x.res = res; x.ex = ex; x.er = er; x.lat = lat; x.n0 = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
      sb.delete();
    end
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {trial, result}, 32'd0);
    chk({nm, "_flags"}, {28'd0, busy, done, exact, err}, 32'd0);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    n_rst = 1'b1;
    @(negedge clk);
    chk_all_zero("after_release");

    // Target 0x1234: eq at step 14 with early exit.
    run_start(16'h1234, 16'h1234, 1'b1, 1'b0, EE ? 15 : 17);
    wait_done();

    // Target 0: trial walks one-hot down from the MSB.
    run_start(16'h0000, 16'h0000, 1'b0, 1'b0, 17);
    for (int k = 1; k <= 16; k++) begin
      chk("zero_walk", {16'd0, trial}, {16'd0, 16'h8000 >> (k - 1)});
      if (k < 16) @(negedge clk);
    end
    wait_done();

    // Target 0xFFFF: eq only at the last step.
    run_start(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17);
    repeat (15) @(negedge clk);
    chk("ffff_step16_trial", {16'd0, trial}, 32'h0000FFFF);
    chk("ffff_step16_eq", {31'd0, cmp_eq}, 32'd1);
    wait_done();

    // Target 0x8000: eq at step 1.
    run_start(16'h8000, 16'h8000, 1'b1, 1'b0, EE ? 2 : 17);
    wait_done();

    // Start pulsed while busy must not restart the search.
    run_start(16'h1234, 16'h1234, 1'b1, 1'b0, EE ? 15 : 17);
    repeat (4) @(negedge clk);
    chk("busy_step5_trial", {16'd0, trial}, 32'h00001800);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_step6_trial", {16'd0, trial}, 32'h00001400);
    chk("busy_still", {31'd0, busy}, 32'd1);
    wait_done();

    // Illegal flags at step 3.
    run_start(16'h1234, 16'h2000, 1'b0, 1'b1, 4);
    repeat (2) @(negedge clk);
    chk("err_step3_trial", {16'd0, trial}, 32'h00002000);
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    chk("err_trial_cleared", {16'd0, trial}, 32'd0);
    wait_done();

    // Asynchronous reset at step 8 aborts with no done pulse.
    run_start(16'h1234, 16'h1234, 1'b1, 1'b0, EE ? 15 : 17);
    repeat (7) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("no_done_after_reset", {31'd0, seen}, 32'd0);

    run_start(16'h00FF, 16'h00FF, 1'b1, 1'b0, 17);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
